// File: rtl/ir_nec_pkg.sv
// Shared NEC protocol definitions: transmitter state encoding, unit durations and payload layout.
// The unit constants are common to the transmit and receive sides.
package ir_nec_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StLeadMark,
    StLeadSpace,
    StBitMark,
    StBitSpace,
    StStopMark,
    StGap,
    StRepMark,
    StRepSpace,
    StRepStop
  } ir_state_e;

  localparam int unsigned LEAD_MARK_U  = 16;
  localparam int unsigned LEAD_SPACE_U = 8;
  localparam int unsigned REP_SPACE_U  = 4;
  localparam int unsigned ONE_SPACE_U  = 3;
  localparam int unsigned ZERO_SPACE_U = 1;
  localparam int unsigned BIT_MARK_U   = 1;
  localparam int unsigned STOP_MARK_U  = 1;
  localparam int unsigned NEC_BITS     = 32;

  // Longest possible frame (all ones) plus at least one unit of gap.
  localparam int unsigned MIN_FRAME_U =
      LEAD_MARK_U + LEAD_SPACE_U + NEC_BITS * (ONE_SPACE_U + BIT_MARK_U) + STOP_MARK_U + 1;

  // Wire order, LSB first: addr, ~addr, cmd, ~cmd.
  function automatic logic [31:0] nec_payload(input logic [15:0] code);
    return {~code[7:0], code[7:0], ~code[15:8], code[15:8]};
  endfunction

  function automatic logic is_mark(input ir_state_e s);
    return s inside {StLeadMark, StBitMark, StStopMark, StRepMark, StRepStop};
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier divider for the IR LED: high for the first half of each period.
// A synchronous restart realigns the phase so a mark always opens with a full high half-period.
module ir_carrier_gen #(
  parameter int unsigned CARRIER_DIV = 711
) (
  input  logic clk27,
  input  logic reset_n,
  input  logic restart_i,
  output logic carrier_o
);

  localparam int unsigned CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i || (cnt_q == CW'(CARRIER_DIV - 1))) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign carrier_o = (cnt_q < CW'(CARRIER_DIV / 2));

endmodule

// File: rtl/ir_nec_tx.sv
// NEC infrared transmitter: serialises address/command frames and repeat codes as an envelope
// (1 = space) plus a carrier-gated LED drive.
module ir_nec_tx
  import ir_nec_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 15188,
  parameter int unsigned CARRIER_DIV = 711,
  parameter int unsigned FRAME_UNITS = 192
) (
  input  logic        clk27,
  input  logic        reset_n,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [15:0] tx_code,
  input  logic        tx_repeat,
  output logic        ir_tx,
  output logic        ir_tx_mod,
  output logic        busy,
  output logic        done
);

  localparam int unsigned PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

  if ((FRAME_UNITS > 255) || (FRAME_UNITS < MIN_FRAME_U)) begin : g_frame_units_chk
    $error("ir_nec_tx: FRAME_UNITS must lie in [%0d, 255]", MIN_FRAME_U);
  end

  ir_state_e    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]   unit_q, unit_d;
  logic [7:0]   frame_q, frame_d;
  logic [4:0]   bit_idx_q, bit_idx_d;
  logic [31:0]  shreg_q, shreg_d;
  logic         ir_tx_q, ir_tx_d;
  logic         ready_q, ready_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic         tick;
  logic         last_unit;
  logic [4:0]   dur_m1;
  logic         mark_d;
  logic         restart;
  logic         carrier;

  assign tick = (state_q != StIdle) && (presc_q == PW'(UNIT_CYCLES - 1));

  always_comb begin
    dur_m1 = 5'd0;
    case (state_q)
      StLeadMark:  dur_m1 = 5'(LEAD_MARK_U - 1);
      StLeadSpace: dur_m1 = 5'(LEAD_SPACE_U - 1);
      StBitSpace:  dur_m1 = shreg_q[0] ? 5'(ONE_SPACE_U - 1) : 5'(ZERO_SPACE_U - 1);
      StRepMark:   dur_m1 = 5'(LEAD_MARK_U - 1);
      StRepSpace:  dur_m1 = 5'(REP_SPACE_U - 1);
      default:     dur_m1 = 5'd0;
    endcase
  end

  assign last_unit = tick && (unit_q == dur_m1);

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    unit_d    = unit_q;
    frame_d   = frame_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    done_d    = 1'b0;

    if (state_q != StIdle) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        frame_d = frame_q + 8'd1;
        unit_d  = last_unit ? 5'd0 : unit_q + 5'd1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (tx_valid && ready_q) begin
          state_d   = StLeadMark;
          shreg_d   = nec_payload(tx_code);
          presc_d   = '0;
          unit_d    = 5'd0;
          frame_d   = 8'd0;
          bit_idx_d = 5'd0;
        end
      end
      StLeadMark:  if (last_unit) state_d = StLeadSpace;
      StLeadSpace: if (last_unit) state_d = StBitMark;
      StBitMark:   if (last_unit) state_d = StBitSpace;
      StBitSpace: begin
        if (last_unit) begin
          shreg_d   = shreg_q >> 1;
          bit_idx_d = bit_idx_q + 5'd1;
          state_d   = (bit_idx_q == 5'(NEC_BITS - 1)) ? StStopMark : StBitMark;
        end
      end
      StStopMark: begin
        if (last_unit) begin
          state_d = StGap;
          done_d  = 1'b1;
        end
      end
      StGap: begin
        // Gap length is set by the frame counter, not the per-state unit counter.
        unit_d = 5'd0;
        if (tick && (frame_q == 8'(FRAME_UNITS - 1))) begin
          frame_d = 8'd0;
          state_d = tx_repeat ? StRepMark : StIdle;
        end
      end
      StRepMark:  if (last_unit) state_d = StRepSpace;
      StRepSpace: if (last_unit) state_d = StRepStop;
      StRepStop: begin
        if (last_unit) begin
          state_d = StGap;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign mark_d  = is_mark(state_d);
  assign ir_tx_d = ~mark_d;
  assign ready_d = (state_d == StIdle);
  assign busy_d  = (state_d != StIdle);
  // ir_tx_q high means the line is currently in a space, so this fires on every mark entry.
  assign restart = mark_d && ir_tx_q;

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      unit_q    <= 5'd0;
      frame_q   <= 8'd0;
      bit_idx_q <= 5'd0;
      shreg_q   <= 32'd0;
      ir_tx_q   <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      unit_q    <= unit_d;
      frame_q   <= frame_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      ir_tx_q   <= ir_tx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  ir_carrier_gen #(
    .CARRIER_DIV(CARRIER_DIV)
  ) u_carrier (
    .clk27    (clk27),
    .reset_n  (reset_n),
    .restart_i(restart),
    .carrier_o(carrier)
  );

  assign ir_tx     = ir_tx_q;
  assign ir_tx_mod = ~ir_tx_q & carrier;
  assign tx_ready  = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ir_nec_tx.sv
// Bench for ir_nec_tx at reduced timing: envelope edges, done pulses, carrier phase and
// handshake timing are compared against a transition-time model built from the NEC rules.
module tb_ir_nec_tx;

  localparam int unsigned U  = 4;
  localparam int unsigned CD = 2;
  localparam int unsigned FU = 192;
  localparam int         FP = FU * U;

  logic        clk27 = 1'b0;
  logic        reset_n;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] tx_code;
  logic        tx_repeat;
  logic        ir_tx;
  logic        ir_tx_mod;
  logic        busy;
  logic        done;

  int n_chk = 0;
  int n_fail = 0;
  int exp_tr[$];
  int exp_dn[$];

  typedef struct {
    logic [15:0] code;
    int          reps;
    int          exp_ready;
    int          exp_done;
  } vec_t;

  vec_t vecs[4];

  ir_nec_tx #(
    .UNIT_CYCLES(U),
    .CARRIER_DIV(CD),
    .FRAME_UNITS(FU)
  ) dut (
    .clk27    (clk27),
    .reset_n  (reset_n),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_code  (tx_code),
    .tx_repeat(tx_repeat),
    .ir_tx    (ir_tx),
    .ir_tx_mod(ir_tx_mod),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk27 = ~clk27;

  function automatic bit check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      return 1'b0;
    end
    return 1'b1;
  endfunction

  // Expected ir_tx transition times (cycles after accept) and done pulse times.
  function automatic void build_expect(input logic [15:0] code, input int reps);
    logic [31:0] data;
    int cur;
    int s;
    exp_tr.delete();
    exp_dn.delete();
    data = {~code[7:0], code[7:0], ~code[15:8], code[15:8]};
    cur = 0;
    exp_tr.push_back(cur);
    cur += 16 * U; exp_tr.push_back(cur);
    cur += 8 * U;  exp_tr.push_back(cur);
    for (int i = 0; i < 32; i++) begin
      cur += U; exp_tr.push_back(cur);
      cur += (data[i] ? 3 : 1) * U; exp_tr.push_back(cur);
    end
    cur += U; exp_tr.push_back(cur);
    exp_dn.push_back(cur);
    for (int r = 1; r <= reps; r++) begin
      s = r * FP;
      exp_tr.push_back(s);
      exp_tr.push_back(s + 64);
      exp_tr.push_back(s + 80);
      exp_tr.push_back(s + 84);
      exp_dn.push_back(s + 84);
    end
  endfunction

  // Caller leaves tx_valid=1 at a sample where tx_ready=1; the next edge accepts (t=0).
  task automatic run_frame(input string tag, input logic [15:0] code, input int reps,
                           input int exp_ready, input int exp_done, input bit keep_valid,
                           input logic [15:0] next_code);
    int t, ms, bound, carrier_bad, busy_bad;
    logic prev;
    bit timed_out;
    int act_tr[$];
    int act_dn[$];
    build_expect(code, reps);
    t = 0; ms = 0; prev = 1'b1; carrier_bad = 0; busy_bad = 0; timed_out = 1'b0;
    bound = (reps + 1) * FP + 20;
    @(posedge clk27); #1;
    if (keep_valid) tx_code = next_code;
    else tx_valid = 1'b0;
    tx_repeat = (reps > 0);
    while (1) begin
      if (ir_tx !== prev) begin
        act_tr.push_back(t);
        prev = ir_tx;
        if (ir_tx === 1'b0) ms = t;
      end
      if (done === 1'b1) act_dn.push_back(t);
      if (ir_tx === 1'b0) begin
        if (ir_tx_mod !== ((((t - ms) % CD) < (CD / 2)) ? 1'b1 : 1'b0)) carrier_bad++;
      end else if (ir_tx_mod !== 1'b0) carrier_bad++;
      if (tx_ready === 1'b1) break;
      if (busy !== 1'b1) busy_bad++;
      if ((reps > 0) && (t == reps * FP + 100)) tx_repeat = 1'b0;
      if (t >= bound) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge clk27); #1;
      t++;
    end
    void'(check({tag, " timeout"}, 64'(timed_out), 64'd0));
    void'(check({tag, " ready_cycle"}, 64'(t), 64'(exp_ready)));
    void'(check({tag, " busy_at_ready"}, 64'(busy), 64'd0));
    void'(check({tag, " busy_bad_cycles"}, 64'(busy_bad), 64'd0));
    void'(check({tag, " carrier_bad_cycles"}, 64'(carrier_bad), 64'd0));
    if (check({tag, " edge_count"}, 64'(act_tr.size()), 64'(exp_tr.size()))) begin
      for (int i = 0; i < exp_tr.size(); i++) begin
        if (!check($sformatf("%s edge%0d", tag, i), 64'(act_tr[i]), 64'(exp_tr[i]))) break;
      end
    end
    if (check({tag, " done_count"}, 64'(act_dn.size()), 64'(exp_done))) begin
      for (int i = 0; i < exp_dn.size(); i++) begin
        void'(check($sformatf("%s done%0d", tag, i), 64'(act_dn[i]), 64'(exp_dn[i])));
      end
    end
  endtask

  task automatic check_idle(input string tag);
    void'(check({tag, " ir_tx"}, 64'(ir_tx), 64'd1));
    void'(check({tag, " ir_tx_mod"}, 64'(ir_tx_mod), 64'd0));
    void'(check({tag, " tx_ready"}, 64'(tx_ready), 64'd1));
    void'(check({tag, " busy"}, 64'(busy), 64'd0));
    void'(check({tag, " done"}, 64'(done), 64'd0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{code: 16'h00FF, reps: 0, exp_ready: FP,     exp_done: 1};
    vecs[1] = '{code: 16'hA55A, reps: 2, exp_ready: 3 * FP, exp_done: 3};
    vecs[2] = '{code: 16'h3CC3, reps: 0, exp_ready: FP,     exp_done: 1};
    vecs[3] = '{code: 16'hFFFF, reps: 1, exp_ready: 2 * FP, exp_done: 2};

    reset_n = 1'b0; tx_valid = 1'b0; tx_code = 16'h0000; tx_repeat = 1'b0;
    #23;
    check_idle("reset");
    @(negedge clk27); reset_n = 1'b1;
    @(posedge clk27); #1;
    check_idle("post_reset");

    foreach (vecs[k]) begin
      tx_code = vecs[k].code;
      tx_valid = 1'b1;
      run_frame($sformatf("vec%0d", k), vecs[k].code, vecs[k].reps, vecs[k].exp_ready,
                vecs[k].exp_done, 1'b0, 16'h0000);
      repeat (3) @(posedge clk27);
      #1;
    end

    // Held tx_valid: the second request waits for the full frame period.
    tx_code = 16'h1234;
    tx_valid = 1'b1;
    run_frame("b2b_first", 16'h1234, 0, FP, 1, 1'b1, 16'h5678);
    run_frame("b2b_second", 16'h5678, 0, FP, 1, 1'b0, 16'h0000);

    // Asynchronous reset in the middle of the leader mark.
    tx_code = 16'h0F0F;
    tx_valid = 1'b1;
    @(posedge clk27); #1;
    tx_valid = 1'b0;
    repeat (20) @(posedge clk27);
    #1;
    void'(check("mid_lead ir_tx", 64'(ir_tx), 64'd0));
    void'(check("mid_lead busy", 64'(busy), 64'd1));
    #2 reset_n = 1'b0;
    #1 check_idle("async_reset");
    @(negedge clk27); reset_n = 1'b1;
    @(posedge clk27); #1;
    tx_code = 16'hC3A5;
    tx_valid = 1'b1;
    run_frame("after_reset", 16'hC3A5, 0, FP, 1, 1'b0, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
